gf180mcu_rst_seq: RTL



---
 rtl/gf180mcu_rst_pkg.sv | 28 ++
 rtl/gf180mcu_rst_sync.sv | 23 ++
 rtl/gf180mcu_rst_seq.sv | 121 ++++++++++++
 3 files changed

// File: rtl/gf180mcu_rst_pkg.sv
// Shared types and parameter checks for the gf180mcu reset sequencer family.
// Imported by the synchronizer and the top-level sequencer.
package gf180mcu_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_IDLE    = 2'd3
  } rst_state_e;

  // One counter serves both the hold window and the inter-stage gap.
  // It must therefore be able to reach the larger of the two.
  function automatic bit rst_params_ok(
    input int num_stages,
    input int sync_depth,
    input int hold_cycles,
    input int stage_gap,
    input int cnt_w
  );
    int cnt_max;
    cnt_max = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
    return (num_stages >= 1) && (sync_depth >= 2) && (hold_cycles >= 1) &&
           (stage_gap >= 1) && (cnt_w >= 1) && (cnt_w < 31) &&
           ((1 << cnt_w) > cnt_max);
  endfunction

endpackage

// File: rtl/gf180mcu_rst_sync.sv
// Async-assert / sync-deassert reset synchronizer, DEPTH flops deep.
// Reusable by any reset domain that needs a clean deassertion edge.
module gf180mcu_rst_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_sync_n_o
);

  logic [DEPTH-1:0] chain_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[DEPTH-2:0], 1'b1};
    end
  end

  assign rst_sync_n_o = chain_q[DEPTH-1];

endmodule

// File: rtl/gf180mcu_rst_seq.sv
// Reset sequencer: synchronizes the raw reset release, holds all RN_OUT nets
// low for a programmed window, then releases them one stage at a time.
module gf180mcu_rst_seq
  import gf180mcu_rst_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_DEPTH  = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 2,
  parameter int CNT_W       = 4
) (
  input  logic                  CLK,
  input  logic                  RN,
  input  logic                  SW_REQ,
  output logic                  SW_ACK,
  output logic [NUM_STAGES-1:0] RN_OUT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [1:0]            STATE_DBG
);

  if (!rst_params_ok(NUM_STAGES, SYNC_DEPTH, HOLD_CYCLES, STAGE_GAP, CNT_W)) begin : g_param_check
    $error("gf180mcu_rst_seq: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic rst_sync_n;

  gf180mcu_rst_sync #(
    .DEPTH(SYNC_DEPTH)
  ) u_sync (
    .clk_i       (CLK),
    .rst_n_i     (RN),
    .rst_sync_n_o(rst_sync_n)
  );

  rst_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rn_out_q, rn_out_d;
  logic                  ack_q, ack_d;

  // Soft-reset handshake: SW_REQ is a level sampled on CLK and is only
  // accepted in IDLE; acceptance is signalled by a one-cycle SW_ACK pulse.
  // Requests seen in any other state are dropped, never queued.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rn_out_d = rn_out_q;
    ack_d    = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        state_d  = ST_HOLD;
        cnt_d    = CNT_ONE;
        rn_out_d = '0;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_CNT) begin
          state_d     = ST_RELEASE;
          cnt_d       = CNT_ONE;
          rn_out_d    = '0;
          rn_out_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        if (rn_out_q[NUM_STAGES-1]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == GAP_CNT) begin
          // Shift in one more released stage; order is fixed LSB first.
          rn_out_d[0] = 1'b1;
          for (int i = 1; i < NUM_STAGES; i++) begin
            rn_out_d[i] = rn_out_q[i-1];
          end
          cnt_d = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        if (SW_REQ) begin
          // Counter starts at 0 so the outputs stay low HOLD_CYCLES full
          // cycles after the accept edge itself.
          state_d  = ST_HOLD;
          cnt_d    = '0;
          rn_out_d = '0;
          ack_d    = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RESET;
        cnt_d    = '0;
        rn_out_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      rn_out_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rn_out_q <= rn_out_d;
      ack_q    <= ack_d;
    end
  end

  assign RN_OUT    = rn_out_q;
  assign SW_ACK    = ack_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = (state_q == ST_IDLE);
  assign STATE_DBG = state_q;

endmodule
